intan_spi_responder: RTL and testbench

//  Emulated Intan RHD2164 peripheral pair: the responder end of the CSn/SCLK/COPI/CIPO link.

---
 rtl/intan_spi_responder_pkg.sv | 73 +++++++
 rtl/intan_spi_responder_if.sv | 11 +
 rtl/intan_spi_responder_sync_edge.sv | 22 ++
 rtl/intan_spi_responder.sv | 151 +++++++++++++++
 tb/tb_intan_spi_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/intan_spi_responder_pkg.sv
// Command set, ROM contents and the command decoder shared by the Intan responder.
package intan_emu_pkg;

  localparam logic [15:0] CMD_CALIBRATE_W = 16'h5500;
  localparam logic [15:0] CMD_CLEAR_W     = 16'h6A00;
  localparam int          WRITABLE_MAX    = 17;
  localparam int          NUM_REGS        = WRITABLE_MAX + 1;

  typedef enum logic [2:0] {
    CMD_CONVERT, CMD_CALIBRATE, CMD_CLEAR, CMD_WRITE, CMD_READ, CMD_OTHER
  } cmd_e;

  typedef enum logic {ST_IDLE, ST_FRAME} state_e;

  typedef logic [NUM_REGS-1:0][7:0] regfile_t;

  typedef struct packed {
    cmd_e        kind;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic [15:0] a;
    logic [15:0] b;
  } decode_t;

  function automatic logic [7:0] rom_read(input logic [5:0] r);
    case (r)
      6'd40:   return 8'h49;
      6'd41:   return 8'h4E;
      6'd42:   return 8'h54;
      6'd43:   return 8'h41;
      6'd44:   return 8'h4E;
      6'd60:   return 8'h01;
      6'd61:   return 8'h00;
      6'd62:   return 8'h40;
      6'd63:   return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  function automatic decode_t decode(input logic [15:0] w, input logic [9:0] samp,
                                     input regfile_t regs);
    decode_t d;
    d.kind = CMD_OTHER;
    d.addr = w[13:8];
    d.data = w[7:0];
    d.a    = '0;
    d.b    = '0;
    case (w[15:14])
      2'b00: begin
        d.kind = CMD_CONVERT;
        d.a    = {w[13:8], samp};
        d.b    = ~d.a;
      end
      2'b10: begin
        // Echo is returned even when the target is not writable.
        d.kind = CMD_WRITE;
        d.a    = {8'hFF, w[7:0]};
        d.b    = d.a;
      end
      2'b11: begin
        d.kind = CMD_READ;
        d.a    = {8'h00, (w[13:8] <= 6'(WRITABLE_MAX)) ? regs[5'(w[13:8])] : rom_read(w[13:8])};
        d.b    = d.a;
      end
      default: begin
        if (w == CMD_CALIBRATE_W)  d.kind = CMD_CALIBRATE;
        else if (w == CMD_CLEAR_W) d.kind = CMD_CLEAR;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/intan_spi_responder_if.sv
// CSn/SCLK/COPI/CIPO link between the acquisition controller and the emulated headstage.
interface intan_spi_responder_if;
  logic csn;
  logic sclk;
  logic copi;
  logic cipo0;
  logic cipo1;

  modport master (output csn, sclk, copi, input  cipo0, cipo1);
  modport slave  (input  csn, sclk, copi, output cipo0, cipo1);
endinterface

// File: rtl/intan_spi_responder_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with rise/fall pulses from a third stage.
module intan_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (!rstn) sh_q <= {3{RST_VAL}};
    else       sh_q <= {sh_q[1:0], d_i};
  end

  assign lvl_o  = sh_q[1];
  assign rise_o =  sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] &  sh_q[2];
endmodule

// File: rtl/intan_spi_responder.sv
// Emulated RHD2164 pair: receives 16-bit commands, returns 32-bit DDR results two frames later
// on cipo0/cipo1 through a selectable cable-delay line.
module intan_spi_responder
  import intan_emu_pkg::*;
#(
  parameter int          MAX_DELAY  = 16,
  parameter logic [15:0] CIPO1_SALT = 16'hA5A5,
  localparam int         DW         = $clog2(MAX_DELAY)
) (
  input  logic                   clk,
  input  logic                   rstn,
  intan_spi_responder_if.slave   spi,
  input  logic [DW-1:0]          delay_cyc_i,
  output logic [31:0]            cmd_count_o,
  output logic [15:0]            last_cmd_o,
  output logic                   protocol_err_o
);
  localparam logic [31:0] SALT32 = {CIPO1_SALT, CIPO1_SALT};

  logic csn_lvl, csn_rise, csn_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;

  // CSn idles high, so its synchronizer resets high to avoid a phantom frame start.
  intan_sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rstn(rstn), .d_i(spi.csn),  .lvl_o(csn_lvl),  .rise_o(csn_rise),  .fall_o(csn_fall));
  intan_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .d_i(spi.sclk), .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  intan_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rstn(rstn), .d_i(spi.copi), .lvl_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

  state_e         state_q, state_d;
  logic [15:0]    rx_q, rx_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [31:0]    tx0_q, tx0_d, tx1_q, tx1_d;
  logic [4:0]     tx_cnt_q, tx_cnt_d;
  logic [31:0]    head_q, head_d, tail_q, tail_d;
  logic [9:0]     samp_q, samp_d;
  regfile_t       regs_q, regs_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [15:0]    last_q, last_d;
  logic           err_q, err_d;
  logic [MAX_DELAY-1:0] dl0_q, dl1_q;

  decode_t dec;
  logic    tx_bit0, tx_bit1;

  assign dec     = decode(rx_q, samp_q, regs_q);
  assign tx_bit0 = (state_q == ST_FRAME) & tx0_q[31];
  assign tx_bit1 = (state_q == ST_FRAME) & tx1_q[31];

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    tx0_d     = tx0_q;
    tx1_d     = tx1_q;
    tx_cnt_d  = tx_cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    samp_d    = samp_q;
    regs_d    = regs_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d   = ST_FRAME;
          bit_cnt_d = '0;
          tx0_d     = head_q;
          tx1_d     = head_q ^ SALT32;
          tx_cnt_d  = '0;
        end
      end
      default: begin
        // CSn events win over a coincident SCLK edge.
        if (csn_rise) begin
          state_d = ST_IDLE;
          if (bit_cnt_q == 5'd16) begin
            cnt_d  = cnt_q + 32'd1;
            last_d = rx_q;
            head_d = tail_q;
            tail_d = {dec.a, dec.b};
            if (dec.kind == CMD_CONVERT && dec.addr == 6'd63) samp_d = samp_q + 10'd1;
            if (dec.kind == CMD_WRITE && dec.addr <= 6'(WRITABLE_MAX))
              regs_d[5'(dec.addr)] = dec.data;
          end else begin
            err_d = 1'b1;
          end
        end else if (!csn_lvl) begin
          if (sclk_rise) begin
            rx_d = {rx_q[14:0], copi_lvl};
            if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if ((sclk_rise || sclk_fall) && tx_cnt_q != 5'd31) begin
            tx0_d    = tx0_q << 1;
            tx1_d    = tx1_q << 1;
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      tx0_q     <= '0;
      tx1_q     <= '0;
      tx_cnt_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      samp_q    <= '0;
      regs_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      err_q     <= 1'b0;
      dl0_q     <= '0;
      dl1_q     <= '0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      tx0_q     <= tx0_d;
      tx1_q     <= tx1_d;
      tx_cnt_q  <= tx_cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      samp_q    <= samp_d;
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      err_q     <= err_d;
      dl0_q     <= {dl0_q[MAX_DELAY-2:0], tx_bit0};
      dl1_q     <= {dl1_q[MAX_DELAY-2:0], tx_bit1};
    end
  end

  // Tap 0 already sits one register after the tx bit, giving 3 + delay + 1 clk pin to pin.
  assign spi.cipo0      = dl0_q[delay_cyc_i];
  assign spi.cipo1      = dl1_q[delay_cyc_i];
  assign cmd_count_o    = cnt_q;
  assign last_cmd_o     = last_q;
  assign protocol_err_o = err_q;
endmodule

// File: tb/tb_intan_spi_responder.sv
// Drives SPI frames at clk/8 SCLK, checks returned words against a vector table and a
// reference-model scoreboard, plus protocol-error, delay-sweep and mid-frame reset sequences.
module tb_intan_spi_responder;
  localparam logic [31:0] SALT32 = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  delay_cyc;
  logic [31:0] cmd_count;
  logic [15:0] last_cmd;
  logic        perr;

  intan_spi_responder_if spi_if();

  intan_spi_responder #(.MAX_DELAY(16), .CIPO1_SALT(16'hA5A5)) dut (
    .clk(clk), .rstn(rstn), .spi(spi_if), .delay_cyc_i(delay_cyc),
    .cmd_count_o(cmd_count), .last_cmd_o(last_cmd), .protocol_err_o(perr));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int nt = 0;
  int fall_nt = 0;
  int first_hi = -1;

  logic [31:0] sb[$];
  logic [7:0]  m_regs [18];
  logic [9:0]  m_samp;

  typedef struct {
    logic [15:0] cmd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [24];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      @(negedge clk);
      nt++;
      if (first_hi < 0 && spi_if.cipo0 === 1'b1) first_hi = nt - fall_nt;
    end
  endtask

  function automatic logic [7:0] m_read(input int r);
    if (r <= 17) return m_regs[r];
    case (r)
      40: return 8'h49;
      41: return 8'h4E;
      42: return 8'h54;
      43: return 8'h41;
      44: return 8'h4E;
      60: return 8'h01;
      62: return 8'h40;
      63: return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [15:0] w);
    logic [15:0] a;
    int r;
    r = int'(w[13:8]);
    a = 16'h0000;
    if (w[15:14] == 2'b00) begin
      a = {w[13:8], m_samp};
      if (r == 63) m_samp = m_samp + 10'd1;
      return {a, ~a};
    end
    if (w[15:14] == 2'b10) begin
      if (r <= 17) m_regs[r] = w[7:0];
      a = {8'hFF, w[7:0]};
    end else if (w[15:14] == 2'b11) begin
      a = {8'h00, m_read(r)};
    end
    return {a, a};
  endfunction

  task automatic model_reset();
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    m_samp = '0;
    for (int i = 0; i < 18; i++) m_regs[i] = 8'h00;
  endtask

  // nbits SCLK periods; cipo sampled 2 clk after each following edge.
  task automatic run_frame(input logic [15:0] cmd, input int nbits, input bit cmp,
                           output logic [31:0] r0, output logic [31:0] r1);
    logic [15:0] sh;
    logic [31:0] exp;
    sh = cmd;
    r0 = '0;
    r1 = '0;
    spi_if.csn  = 1'b0;
    spi_if.copi = sh[15];
    fall_nt  = nt;
    first_hi = -1;
    tk(4);
    for (int k = 0; k < nbits; k++) begin
      spi_if.sclk = 1'b1;
      tk(2);
      r0[31-2*k] = spi_if.cipo0;
      r1[31-2*k] = spi_if.cipo1;
      tk(2);
      spi_if.sclk = 1'b0;
      sh = sh << 1;
      spi_if.copi = sh[15];
      tk(2);
      r0[30-2*k] = spi_if.cipo0;
      r1[30-2*k] = spi_if.cipo1;
      tk(2);
    end
    spi_if.csn = 1'b1;
    tk(24);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
    if (cmp) begin
      check($sformatf("sb_cipo0 cmd=%h", cmd), r0, exp);
      check($sformatf("sb_cipo1 cmd=%h", cmd), r1, exp ^ SALT32);
    end
    if (nbits == 16) sb.push_back(model(cmd));
    else             sb.push_front(exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tk(3);
    rstn = 1'b1;
    tk(2);
    model_reset();
  endtask

  initial begin
    logic [31:0] r0, r1;
    logic [31:0] cnt_before;
    logic [15:0] cmd;
    tbl = '{
      '{16'hE800, 32'h00000000}, '{16'hE900, 32'h00000000},
      '{16'hEA00, 32'h00490049}, '{16'hEB00, 32'h004E004E},
      '{16'hEC00, 32'h00540054}, '{16'h0000, 32'h00410041},
      '{16'h0000, 32'h004E004E}, '{16'h853C, 32'h0000FFFF},
      '{16'hC500, 32'h0000FFFF}, '{16'h0000, 32'hFF3CFF3C},
      '{16'h0000, 32'h003C003C}, '{16'h3F00, 32'h0000FFFF},
      '{16'h3F00, 32'h0000FFFF}, '{16'h5500, 32'hFC0003FF},
      '{16'h6A00, 32'hFC0103FE}, '{16'h4123, 32'h00000000},
      '{16'h9477, 32'h00000000}, '{16'hD400, 32'h00000000},
      '{16'h91AB, 32'hFF77FF77}, '{16'hD100, 32'h00000000},
      '{16'hFC00, 32'hFFABFFAB}, '{16'hFE00, 32'h00AB00AB},
      '{16'h0000, 32'h00010001}, '{16'h0000, 32'h00400040}};

    spi_if.csn  = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.copi = 1'b0;
    delay_cyc   = 4'd0;
    do_reset();
    check("rst_cipo0", {31'b0, spi_if.cipo0}, 32'h0);
    check("rst_cipo1", {31'b0, spi_if.cipo1}, 32'h0);
    check("rst_cmd_count", cmd_count, 32'h0);
    check("rst_last_cmd", {16'h0, last_cmd}, 32'h0);
    check("rst_perr", {31'b0, perr}, 32'h0);

    // ROM reads, write/read-back, convert, calibrate/clear and unwritable targets.
    for (int i = 0; i < 24; i++) begin
      run_frame(tbl[i].cmd, 16, 1'b1, r0, r1);
      check($sformatf("tbl%0d_cipo0", i), r0, tbl[i].exp);
      check($sformatf("tbl%0d_cipo1", i), r1, tbl[i].exp ^ SALT32);
    end
    check("tbl_cmd_count", cmd_count, 32'd24);
    check("tbl_last_cmd", {16'h0, last_cmd}, 32'h0);
    check("tbl_perr", {31'b0, perr}, 32'h0);

    // Short frame: flagged, not counted, pipeline held.
    cnt_before = cmd_count;
    run_frame(16'h8511, 9, 1'b0, r0, r1);
    check("short_perr", {31'b0, perr}, 32'h1);
    check("short_cmd_count", cmd_count, cnt_before);
    run_frame(16'hC500, 16, 1'b1, r0, r1);
    run_frame(16'h0000, 16, 1'b1, r0, r1);
    run_frame(16'h0000, 16, 1'b1, r0, r1);

    // Cable-delay sweep: first 1 of an echo word must land 4+delay clk after CSn falls.
    run_frame(16'h94C3, 16, 1'b1, r0, r1);
    run_frame(16'h94C3, 16, 1'b1, r0, r1);
    for (int d = 0; d < 16; d++) begin
      delay_cyc = 4'(d);
      run_frame(16'h94C3, 16, 1'b0, r0, r1);
      check($sformatf("delay%0d_latency", d), 32'(first_hi), 32'(4 + d));
    end
    delay_cyc = 4'd0;

    // 3 x (CONVERT 0..31, READ 63, two dummies) from a clean reset.
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int f = 0; f < 35; f++) begin
        if (f < 32)       cmd = {2'b00, 6'(f), 8'h00};
        else if (f == 32) cmd = 16'hFF00;
        else              cmd = 16'h0000;
        run_frame(cmd, 16, 1'b1, r0, r1);
      end
    end
    check("loop_cmd_count", cmd_count, 32'd105);
    check("loop_perr", {31'b0, perr}, 32'h0);

    // Reset pulse in the middle of a frame, then finish that frame by hand.
    run_frame(16'h8A5A, 16, 1'b0, r0, r1);
    spi_if.csn  = 1'b0;
    spi_if.copi = 1'b1;
    tk(4);
    repeat (5) begin
      spi_if.sclk = 1'b1; tk(4);
      spi_if.sclk = 1'b0; tk(4);
    end
    rstn = 1'b0;
    tk(1);
    rstn = 1'b1;
    tk(1);
    check("midrst_cipo0", {31'b0, spi_if.cipo0}, 32'h0);
    check("midrst_cipo1", {31'b0, spi_if.cipo1}, 32'h0);
    check("midrst_cmd_count", cmd_count, 32'h0);
    check("midrst_perr", {31'b0, perr}, 32'h0);
    repeat (11) begin
      spi_if.sclk = 1'b1; tk(4);
      spi_if.sclk = 1'b0; tk(4);
    end
    spi_if.csn = 1'b1;
    tk(24);
    model_reset();
    run_frame(16'h853C, 16, 1'b1, r0, r1);
    check("midrst_frame1", r0, 32'h0);
    run_frame(16'hC500, 16, 1'b1, r0, r1);
    check("midrst_frame2", r0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
